// File: rtl/mmio_bus_ctrl.sv
// Handshaked MMIO bus controller: registers one CPU access, decodes a region tag to a
// one-hot slave strobe, waits for that slave's ack (or a timeout) and returns the response.
module mmio_bus_ctrl #(
  parameter int N_SLV   = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int SEL_HI  = 31,
  parameter int SEL_LO  = 28,
  // Slave i owns SLV_TAG[i*TW +: TW]: slave0=A, slave1=C, slave2=E, slave3=F.
  parameter logic [N_SLV*(SEL_HI-SEL_LO+1)-1:0] SLV_TAG = 16'hFECA,
  parameter int DEF_SLV = 0,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [AW-1:0]       cpu_addr,
  input  logic [DW-1:0]       cpu_wdata,
  output logic                cpu_ready,
  output logic [DW-1:0]       cpu_rdata,
  output logic                cpu_err,
  output logic [N_SLV-1:0]    slv_sel,
  output logic                slv_we,
  output logic [AW-1:0]       slv_addr,
  output logic [DW-1:0]       slv_wdata,
  input  logic [N_SLV-1:0]    slv_ack,
  input  logic [N_SLV*DW-1:0] slv_rdata,
  output logic [AW-1:0]       err_addr,
  output logic [7:0]          err_cnt
);

  localparam int TW = SEL_HI - SEL_LO + 1;
  localparam int IW = (N_SLV > 1) ? $clog2(N_SLV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP, S_ERR} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [IW-1:0]   r_idx;
  logic [7:0]      r_tcnt;
  logic [DW-1:0]   r_rdata;
  logic [AW-1:0]   r_err_addr;
  logic [7:0]      r_err_cnt;
  logic            w_ack;
  logic            w_tmo;
  logic [DW-1:0]   w_slv_rd;

  // Scanning from the top down lets the lowest matching index overwrite the others.
  function automatic logic [IW-1:0] f_decode(input logic [AW-1:0] addr);
    logic [IW-1:0] idx;
    idx = IW'(DEF_SLV);
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if (addr[SEL_HI:SEL_LO] == SLV_TAG[i*TW +: TW]) idx = IW'(i);
    end
    return idx;
  endfunction

  assign w_ack    = slv_ack[r_idx];
  assign w_slv_rd = slv_rdata[r_idx*DW +: DW];
  assign w_tmo    = (r_tcnt == 8'(TIMEOUT - 1));

  always_comb begin
    w_state_nxt = r_state;
    cpu_ready   = 1'b0;
    cpu_err     = 1'b0;
    slv_sel     = '0;
    slv_we      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (cpu_req) w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        slv_sel[r_idx] = 1'b1;
        slv_we         = r_we;
        if (w_ack)      w_state_nxt = S_RESP;
        else if (w_tmo) w_state_nxt = S_ERR;
      end
      S_RESP: begin
        cpu_ready   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_ERR: begin
        cpu_ready   = 1'b1;
        cpu_err     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_idx      <= '0;
      r_tcnt     <= '0;
      r_rdata    <= '0;
      r_err_addr <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (cpu_req) begin
            r_we    <= cpu_we;
            r_addr  <= cpu_addr;
            r_wdata <= cpu_wdata;
            r_idx   <= f_decode(cpu_addr);
            r_tcnt  <= '0;
          end
        end
        S_ACCESS: begin
          r_tcnt <= r_tcnt + 8'd1;
          // Error bookkeeping lands on entry to ERR so it is visible alongside cpu_ready.
          if (w_ack) begin
            r_rdata <= r_we ? '0 : w_slv_rd;
          end else if (w_tmo) begin
            r_rdata    <= '1;
            r_err_addr <= r_addr;
            if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_rdata = r_rdata;
  assign slv_addr  = r_addr;
  assign slv_wdata = r_wdata;
  assign err_addr  = r_err_addr;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Self-checking bench for mmio_bus_ctrl: directed scenarios plus randomized accesses
// checked against a transaction-level model of decode, ack/timeout and error bookkeeping.
module tb_mmio_bus_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req;
  logic         cpu_we;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic         cpu_ready;
  logic [31:0]  cpu_rdata;
  logic         cpu_err;
  logic [3:0]   slv_sel;
  logic         slv_we;
  logic [31:0]  slv_addr;
  logic [31:0]  slv_wdata;
  logic [3:0]   slv_ack;
  logic [127:0] slv_rdata;
  logic [31:0]  err_addr;
  logic [7:0]   err_cnt;

  always #5 clk = ~clk;

  mmio_bus_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .slv_sel(slv_sel), .slv_we(slv_we), .slv_addr(slv_addr), .slv_wdata(slv_wdata),
    .slv_ack(slv_ack), .slv_rdata(slv_rdata),
    .err_addr(err_addr), .err_cnt(err_cnt)
  );

  localparam logic [3:0] TAGS [4] = '{4'hA, 4'hC, 4'hE, 4'hF};

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [7:0]  m_err_cnt;
  logic [31:0] m_err_addr;
  logic [31:0] m_rdata;
  logic [31:0] srd [4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Region table lookup: first table entry whose tag equals the top nibble, else RAM (0).
  function automatic int model_idx(input logic [31:0] a);
    for (int i = 0; i < 4; i++) if (a[31:28] == TAGS[i]) return i;
    return 0;
  endfunction

  task automatic load_srd(input bit rand_all);
    if (rand_all) for (int i = 0; i < 4; i++) srd[i] = $urandom;
    slv_rdata = {srd[3], srd[2], srd[1], srd[0]};
  endtask

  // One CPU access. ack_at = ACCESS cycle (1-based) in which the selected slave acks; outside
  // 1..15 means it never acks in time. noise = unselected slaves that ack every cycle.
  // Returns in the cpu_ready cycle with cpu_req still asserted.
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int ack_at, input logic [3:0] noise, input bit from_resp);
    int          idx;
    int          k;
    int          exp_cyc;
    bit          exp_err;
    logic [31:0] exp_rd;
    logic [3:0]  oh;
    idx     = model_idx(addr);
    oh      = 4'b0001 << idx;
    exp_err = !(ack_at >= 1 && ack_at <= 15);
    exp_cyc = exp_err ? 15 : ack_at;
    exp_rd  = exp_err ? 32'hFFFF_FFFF : (we ? 32'h0 : srd[idx]);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    step();
    if (from_resp) begin
      n_checks++;
      if ({cpu_ready, slv_sel} !== 5'b0)
        $display("FAIL b2b_idle: ready/sel=%b required 00000", {cpu_ready, slv_sel});
      else n_pass++;
      step();
    end
    k = 1;
    while (cpu_ready !== 1'b1 && k <= 40) begin
      n_checks++;
      if ({slv_sel, slv_we, slv_addr, slv_wdata} !== {oh, we, addr, wdata})
        $display("FAIL access_bus cyc%0d: sel=%b we=%b addr=%h wd=%h required sel=%b we=%b addr=%h wd=%h",
                 k, slv_sel, slv_we, slv_addr, slv_wdata, oh, we, addr, wdata);
      else n_pass++;
      slv_ack = ((k == ack_at) ? oh : 4'b0) | (noise & ~oh);
      step();
      k++;
    end
    slv_ack = 4'b0;
    n_checks++;
    if (k - 1 !== exp_cyc)
      $display("FAIL access_cycles @%h: got %0d required %0d", addr, k - 1, exp_cyc);
    else n_pass++;
    n_checks++;
    if ({cpu_ready, cpu_err, cpu_rdata} !== {1'b1, exp_err, exp_rd})
      $display("FAIL response @%h: ready=%b err=%b rdata=%h required 1 %b %h",
               addr, cpu_ready, cpu_err, cpu_rdata, exp_err, exp_rd);
    else n_pass++;
    n_checks++;
    if ({slv_sel, slv_we} !== 5'b0)
      $display("FAIL resp_sel: sel/we=%b required 00000", {slv_sel, slv_we});
    else n_pass++;
    if (exp_err) begin
      m_err_addr = addr;
      if (m_err_cnt != 8'hFF) m_err_cnt = m_err_cnt + 8'd1;
    end
    n_checks++;
    if ({err_addr, err_cnt} !== {m_err_addr, m_err_cnt})
      $display("FAIL err_regs: addr=%h cnt=%0d required addr=%h cnt=%0d",
               err_addr, err_cnt, m_err_addr, m_err_cnt);
    else n_pass++;
    m_rdata = exp_rd;
  endtask

  task automatic idle_gap();
    cpu_req = 1'b0;
    step();
    n_checks++;
    if ({cpu_ready, cpu_err, slv_sel, cpu_rdata} !== {2'b00, 4'b0, m_rdata})
      $display("FAIL idle_hold: ready=%b err=%b sel=%b rdata=%h required 0 0 0000 %h",
               cpu_ready, cpu_err, slv_sel, cpu_rdata, m_rdata);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; slv_ack = '0;
    for (int i = 0; i < 4; i++) srd[i] = '0;
    load_srd(1'b0);
    step(); step();
    n_checks++;
    if ({cpu_ready, cpu_err, cpu_rdata, slv_sel, slv_we, slv_addr, slv_wdata, err_addr, err_cnt} !== '0)
      $display("FAIL reset_outputs: ready=%b err=%b rdata=%h sel=%b we=%b addr=%h wd=%h eaddr=%h ecnt=%0d required all 0",
               cpu_ready, cpu_err, cpu_rdata, slv_sel, slv_we, slv_addr, slv_wdata, err_addr, err_cnt);
    else n_pass++;
    rst = 1'b1;
    m_err_cnt = '0; m_err_addr = '0; m_rdata = '0;
    idle_gap();
  endtask

  task automatic test_read_decode();
    load_srd(1'b1);
    srd[1] = 32'h0000_0ABC;
    load_srd(1'b0);
    do_access(1'b0, 32'hC000_0010, 32'h0, 2, 4'b0, 1'b0);
    idle_gap();
  endtask

  task automatic test_write_default();
    load_srd(1'b1);
    do_access(1'b1, 32'h0000_0040, 32'h1234_5678, 1, 4'b0, 1'b0);
    idle_gap();
  endtask

  task automatic test_timeout();
    load_srd(1'b1);
    do_access(1'b0, 32'hA000_0000, 32'h0, 0, 4'b0, 1'b0);
    idle_gap();
  endtask

  task automatic test_ack_last_cycle();
    load_srd(1'b1);
    do_access(1'b0, 32'hE000_0100, 32'h0, 15, 4'b0, 1'b0);
    idle_gap();
  endtask

  task automatic test_foreign_ack();
    load_srd(1'b1);
    do_access(1'b0, 32'hC000_0200, 32'h0, 6, 4'b1000, 1'b0);
    idle_gap();
    do_access(1'b1, 32'hC000_0204, 32'hDEAD_BEEF, 0, 4'b1101, 1'b0);
    idle_gap();
  endtask

  task automatic test_reset_mid();
    load_srd(1'b1);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hC000_0020;
    step(); step(); step();
    n_checks++;
    if (slv_sel !== 4'b0010) $display("FAIL pre_reset_sel: sel=%b required 0010", slv_sel);
    else n_pass++;
    rst = 1'b0; cpu_req = 1'b0;
    step();
    n_checks++;
    if ({slv_sel, cpu_ready, cpu_rdata, err_addr, err_cnt} !== '0)
      $display("FAIL mid_reset: sel=%b ready=%b rdata=%h eaddr=%h ecnt=%0d required all 0",
               slv_sel, cpu_ready, cpu_rdata, err_addr, err_cnt);
    else n_pass++;
    rst = 1'b1;
    m_err_cnt = '0; m_err_addr = '0; m_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({cpu_ready, slv_sel} !== 5'b0)
        $display("FAIL post_reset_idle: ready/sel=%b required 00000", {cpu_ready, slv_sel});
      else n_pass++;
    end
    do_access(1'b0, 32'hF000_0008, 32'h0, 3, 4'b0, 1'b0);
    idle_gap();
  endtask

  task automatic test_back_to_back();
    load_srd(1'b1);
    do_access(1'b0, 32'hA000_0004, 32'h0, 1, 4'b0, 1'b0);
    do_access(1'b1, 32'hE000_0008, 32'h5555_AAAA, 1, 4'b0, 1'b1);
    do_access(1'b0, 32'hF000_000C, 32'h0, 1, 4'b0, 1'b1);
    idle_gap();
  endtask

  task automatic test_random();
    logic [3:0]  nib;
    logic [31:0] addr;
    int          r;
    int          ack_at;
    bit          b2b;
    for (int n = 0; n < 40; n++) begin
      r   = $urandom_range(0, 5);
      nib = (r < 4) ? TAGS[r] : 4'($urandom);
      addr = {nib, 28'($urandom)};
      ack_at = ($urandom_range(0, 3) == 0) ? $urandom_range(14, 17) : $urandom_range(1, 8);
      b2b = (n != 0) && ($urandom_range(0, 1) == 1);
      if (n != 0 && !b2b) idle_gap();
      load_srd(1'b1);
      do_access(1'($urandom), addr, $urandom, ack_at, 4'($urandom), b2b);
    end
    idle_gap();
  endtask

  task automatic test_err_saturate();
    load_srd(1'b1);
    while (m_err_cnt != 8'hFF) begin
      do_access(1'b0, {4'h3, 28'($urandom)}, 32'h0, 0, 4'b1110, 1'b1 && 1'b0);
      idle_gap();
    end
    for (int i = 0; i < 2; i++) begin
      do_access(1'b0, {4'hA, 28'($urandom)}, 32'h0, 0, 4'b0, 1'b0);
      idle_gap();
    end
  endtask

  initial begin
    test_reset();
    test_read_decode();
    test_write_default();
    test_timeout();
    test_ack_last_cycle();
    test_foreign_ack();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_err_saturate();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
